theta_phase_gate: RTL and testbench

- Upstream stage of ca3_phase_memory. Takes the theta oscillator x-output and tracks peaks and troughs with hysteresis.
- Produces registered peak/trough pulses plus encode (post-peak) and retrieve (post-trough) windows, so CA3 learning and recall can be gated and pattern_in can be presented.
- Measures the theta period in clk_en samples and reports frequency lock.

---
 rtl/theta_phase_gate.sv | 140 ++++++++++++++
 tb/tb_theta_phase_gate.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/theta_phase_gate.sv
// Theta phase gate: hysteretic peak/trough tracking of the theta oscillator, encode/retrieve
// windows for CA3 gating, and period measurement with frequency lock.
module theta_phase_gate #(
   parameter int          WIDTH      = 18,
   parameter int          HI_THRESH  = 12288,
   parameter int          LO_THRESH  = -12288,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned ENC_LEN    = 64,
   parameter int unsigned RET_LEN    = 64,
   parameter int unsigned MIN_PERIOD = 400,
   parameter int unsigned MAX_PERIOD = 1000,
   parameter int unsigned LOCK_TOL   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   input  logic signed [WIDTH-1:0] theta_x,
   output logic                    peak_pulse,
   output logic                    trough_pulse,
   output logic                    encode_window,
   output logic                    retrieve_window,
   output logic [CNT_W-1:0]        period,
   output logic                    period_valid,
   output logic                    locked,
   output logic [CNT_W-1:0]        cycle_count
);

   localparam logic signed [WIDTH-1:0] HiTh      = WIDTH'(HI_THRESH);
   localparam logic signed [WIDTH-1:0] LoTh      = WIDTH'(LO_THRESH);
   localparam logic [CNT_W-1:0]        EncLen    = CNT_W'(ENC_LEN);
   localparam logic [CNT_W-1:0]        RetLen    = CNT_W'(RET_LEN);
   localparam logic [CNT_W-1:0]        MinPer    = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0]        MaxPer    = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0]        LockTol   = CNT_W'(LOCK_TOL);
   localparam logic [CNT_W-1:0]        LossCnt   = CNT_W'(MAX_PERIOD + 1);

   typedef enum logic [1:0] {StUnk, StHigh, StLow} state_e;

   state_e           st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, diff;
   logic [CNT_W-1:0] period_q, period_d, cyc_q, cyc_d;
   logic [CNT_W-1:0] enc_q, enc_d, ret_q, ret_d;
   logic             seen_q, seen_d, valid_q, valid_d, lock_q, lock_d;
   logic             ppulse_q, ppulse_d, tpulse_q, tpulse_d;
   logic             is_hi, is_lo, peak_ev, trough_ev, sig_loss;
   logic             new_ok, old_ok;

   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      cyc_d    = cyc_q;
      enc_d    = enc_q;
      ret_d    = ret_q;
      seen_d   = seen_q;
      valid_d  = valid_q;
      lock_d   = lock_q;
      ppulse_d = 1'b0;
      tpulse_d = 1'b0;

      is_hi     = theta_x >= HiTh;
      is_lo     = theta_x <= LoTh;
      cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      peak_ev   = clk_en && (st_q != StHigh) && is_hi;
      trough_ev = clk_en && (st_q != StLow) && is_lo;
      // One-shot: the counter passes LossCnt exactly once between peaks.
      sig_loss  = clk_en && (cnt_q == LossCnt) && !peak_ev;
      diff      = (cnt_inc >= period_q) ? cnt_inc - period_q : period_q - cnt_inc;
      new_ok    = (cnt_inc >= MinPer) && (cnt_inc <= MaxPer);
      old_ok    = (period_q >= MinPer) && (period_q <= MaxPer);

      if (clk_en) begin
         cnt_d = cnt_inc;
         enc_d = (enc_q != '0) ? enc_q - 1'b1 : '0;
         ret_d = (ret_q != '0) ? ret_q - 1'b1 : '0;
         if (peak_ev) begin
            st_d     = StHigh;
            ppulse_d = 1'b1;
            cyc_d    = cyc_q + 1'b1;
            enc_d    = EncLen;
            ret_d    = '0;
            cnt_d    = '0;
            seen_d   = 1'b1;
            lock_d   = 1'b0;
            if (seen_q) begin
               period_d = cnt_inc;
               valid_d  = 1'b1;
               lock_d   = valid_q && (diff <= LockTol) && new_ok && old_ok;
            end
         end else if (trough_ev) begin
            st_d     = StLow;
            tpulse_d = 1'b1;
            ret_d    = RetLen;
            enc_d    = '0;
         end
         if (sig_loss) begin
            st_d   = StUnk;
            lock_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= StUnk;
         cnt_q    <= '0;
         period_q <= '0;
         cyc_q    <= '0;
         enc_q    <= '0;
         ret_q    <= '0;
         seen_q   <= 1'b0;
         valid_q  <= 1'b0;
         lock_q   <= 1'b0;
         ppulse_q <= 1'b0;
         tpulse_q <= 1'b0;
      end else begin
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         cyc_q    <= cyc_d;
         enc_q    <= enc_d;
         ret_q    <= ret_d;
         seen_q   <= seen_d;
         valid_q  <= valid_d;
         lock_q   <= lock_d;
         ppulse_q <= ppulse_d;
         tpulse_q <= tpulse_d;
      end
   end

   assign peak_pulse      = ppulse_q;
   assign trough_pulse    = tpulse_q;
   assign encode_window   = enc_q != '0;
   assign retrieve_window = ret_q != '0;
   assign period          = period_q;
   assign period_valid    = valid_q;
   assign locked          = lock_q;
   assign cycle_count     = cyc_q;

endmodule

// File: tb/tb_theta_phase_gate.sv
// Directed bench for theta_phase_gate: reset, windows, period/lock, hysteresis, loss, gating.
module tb_theta_phase_gate;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               clk_en = 1'b0;
   logic signed [17:0] theta_x = '0;
   logic               peak_pulse, trough_pulse, encode_window, retrieve_window;
   logic [15:0]        period, cycle_count;
   logic               period_valid, locked;

   int n_vec = 0;
   int n_err = 0;

   theta_phase_gate dut (
      .clk             (clk),
      .rst             (rst),
      .clk_en          (clk_en),
      .theta_x         (theta_x),
      .peak_pulse      (peak_pulse),
      .trough_pulse    (trough_pulse),
      .encode_window   (encode_window),
      .retrieve_window (retrieve_window),
      .period          (period),
      .period_valid    (period_valid),
      .locked          (locked),
      .cycle_count     (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Apply one clock with the given input, then settle past the edge.
   task automatic step(input logic signed [17:0] x, input logic en);
      theta_x = x;
      clk_en  = en;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (5) step(18'sd0, 1'b1);
      rst = 1'b0;
   endtask

   initial begin
      int npk;
      #1;
      // Reset state
      do_reset();
      chk("rst_peak", 32'(peak_pulse), 0);
      chk("rst_trough", 32'(trough_pulse), 0);
      chk("rst_enc", 32'(encode_window), 0);
      chk("rst_ret", 32'(retrieve_window), 0);
      chk("rst_period", 32'(period), 0);
      chk("rst_valid", 32'(period_valid), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_cycles", 32'(cycle_count), 0);
      step(18'sd0, 1'b1);
      step(18'sd13000, 1'b1);
      chk("first_peak_pulse", 32'(peak_pulse), 1);
      chk("first_peak_valid", 32'(period_valid), 0);

      // Single peak and encode window length
      do_reset();
      step(18'sd13000, 1'b1);
      chk("sp_pulse", 32'(peak_pulse), 1);
      chk("sp_enc", 32'(encode_window), 1);
      chk("sp_cycles", 32'(cycle_count), 1);
      step(18'sd0, 1'b1);
      chk("sp_pulse_clear", 32'(peak_pulse), 0);
      repeat (62) step(18'sd0, 1'b1);
      chk("sp_enc_last", 32'(encode_window), 1);
      step(18'sd0, 1'b1);
      chk("sp_enc_end", 32'(encode_window), 0);

      // Trough cuts encode window short
      do_reset();
      step(18'sd13000, 1'b1);
      repeat (9) step(18'sd0, 1'b1);
      step(-18'sd13000, 1'b1);
      chk("early_trough", 32'(trough_pulse), 1);
      chk("early_enc", 32'(encode_window), 0);
      chk("early_ret", 32'(retrieve_window), 1);
      step(18'sd13000, 1'b1);
      chk("early_ret_cut", 32'(retrieve_window), 0);
      chk("early_enc_on", 32'(encode_window), 1);

      // Square wave, period 600
      do_reset();
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 300; i++) begin
            step(18'sd13000, 1'b1);
            if (i == 0) begin
               chk($sformatf("sq%0d_peak", p), 32'(peak_pulse), 1);
               chk($sformatf("sq%0d_locked", p), 32'(locked), (p >= 2) ? 1 : 0);
               if (p >= 1) begin
                  chk($sformatf("sq%0d_period", p), 32'(period), 600);
                  chk($sformatf("sq%0d_valid", p), 32'(period_valid), 1);
               end
            end
         end
         for (int i = 0; i < 300; i++) begin
            step(-18'sd13000, 1'b1);
            if (i == 0) begin
               chk($sformatf("sq%0d_trough", p), 32'(trough_pulse), 1);
               chk($sformatf("sq%0d_ret", p), 32'(retrieve_window), 1);
               chk($sformatf("sq%0d_enc_off", p), 32'(encode_window), 0);
            end
         end
      end
      chk("sq_cycles", 32'(cycle_count), 4);
      chk("sq_locked_end", 32'(locked), 1);

      // Signal loss after lock
      repeat (1001) step(18'sd0, 1'b1);
      chk("loss_locked", 32'(locked), 0);
      chk("loss_period", 32'(period), 600);
      chk("loss_valid", 32'(period_valid), 1);
      step(18'sd13000, 1'b1);
      chk("loss_repeak", 32'(peak_pulse), 1);
      chk("loss_period_long", 32'(period), 1601);
      chk("loss_still_unlocked", 32'(locked), 0);
      chk("loss_cycles", 32'(cycle_count), 5);

      // Hysteresis at the inclusive threshold
      do_reset();
      npk = 0;
      for (int i = 0; i < 200; i++) begin
         step((i % 2 == 0) ? 18'sd12288 : 18'sd11000, 1'b1);
         if (peak_pulse) npk++;
      end
      chk("hyst_peaks", 32'(npk), 1);
      chk("hyst_cycles", 32'(cycle_count), 1);
      step(-18'sd12288, 1'b1);
      chk("hyst_lo_incl", 32'(trough_pulse), 1);

      // Gating and reset mid-window
      do_reset();
      repeat (3) step(18'sd13000, 1'b0);
      chk("gate_nopulse", 32'(peak_pulse), 0);
      chk("gate_nocycle", 32'(cycle_count), 0);
      step(18'sd13000, 1'b1);
      chk("gate_pulse", 32'(peak_pulse), 1);
      step(18'sd13000, 1'b0);
      chk("gate_pulse_clear", 32'(peak_pulse), 0);
      chk("gate_enc_hold", 32'(encode_window), 1);
      repeat (9) step(18'sd0, 1'b1);
      chk("mid_enc_on", 32'(encode_window), 1);
      rst = 1'b1;
      step(18'sd0, 1'b1);
      chk("mid_rst_enc", 32'(encode_window), 0);
      chk("mid_rst_cycles", 32'(cycle_count), 0);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
